multicycle_controller: RTL

//  Moore FSM controller for the multicycle MIPS datapath; sits directly upstream of the ALU.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared constants for the multicycle MIPS control path: opcode and funct
//   encodings, ALU control codes, operand/PC select codes, the ALU-operation
//   class the FSM hands to the ALU decoder, and the controller state encoding.
//   No ports; imported by multicycle_controller and alu_decoder.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU operation class emitted by the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Controller state encoding (codes 12..15 unused)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Maps the FSM's ALU operation class plus the R-type funct field onto the
//   3-bit ALU control code.
//   Ports:
//     aluOp      in  2  00 add, 01 sub, 10 decode funct (11 treated as add)
//     funct      in  6  instr[5:0]
//     aluControl out 3  ALU operation code
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] funct,
  output logic [2:0] aluControl
);

  // Operation class first, funct only consulted for R-type execution
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluControl = ALU_ADD;
          FN_SUB:  aluControl = ALU_SUB;
          FN_AND:  aluControl = ALU_AND;
          FN_OR:   aluControl = ALU_OR;
          FN_SLT:  aluControl = ALU_SLT;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore FSM controlling the multicycle MIPS datapath. Only the state is
//   registered; all outputs are a combinational decode of the state (pcEn
//   additionally uses the ALU zero flag to resolve beq).
//   Parameters: SUPPORT_ADDI / SUPPORT_J enable addi / j; when 0 the opcode
//   is illegal and runs as a 2-cycle nop with illegalOp pulsed in DECODE.
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     opcode, funct          fields of the instruction register
//     zero                   ALU flag, 0 when the ALU result is zero
//     iord, memWrite         memory address select, memory write enable
//     irWrite                instruction register load
//     regDst, memToReg       register file write address/data selects
//     regWrite               register file write enable
//     aluSrcA, aluSrcB       ALU operand selects
//     aluControl             ALU operation code
//     pcSrc, pcEn            next-PC select and PC load enable
//     illegalOp              unsupported opcode seen in DECODE
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int unsigned SUPPORT_ADDI = 1,
  parameter int unsigned SUPPORT_J    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic [1:0] pcSrc,
  output logic       pcEn,
  output logic       illegalOp
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] dec_state_s;
  logic       op_legal_s;
  logic       is_addi_s;
  logic       is_j_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       pc_write_s;
  logic       branch_s;
  logic       illegal_s;
  logic [1:0] alu_op_s;

  assign is_addi_s  = (SUPPORT_ADDI != 0) && (opcode == OP_ADDI);
  assign is_j_s     = (SUPPORT_J != 0) && (opcode == OP_J);
  assign op_legal_s = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                      (opcode == OP_BEQ) || is_addi_s || is_j_s;

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          state_d = S_EXECUTE;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BEQ;
        end else if (is_addi_s) begin
          state_d = S_ADDIEX;
        end else if (is_j_s) begin
          state_d = S_JUMP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // While reset is high the outputs show the FETCH decode, so the datapath
  // sees a well-defined pattern even before the first reset edge.
  assign dec_state_s = reset ? S_FETCH : state_q;

  // Output decode of the (effective) state
  always_comb begin
    iord        = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    reg_write_s = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REG;
    alu_op_s    = ALUOP_ADD;
    pcSrc       = PC_ALU;
    pc_write_s  = 1'b0;
    branch_s    = 1'b0;
    illegal_s   = 1'b0;
    case (dec_state_s)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        aluSrcB    = SRCB_FOUR;
      end
      S_DECODE: begin
        aluSrcB   = SRCB_IMM_SH;
        illegal_s = ~op_legal_s;
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memToReg    = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA  = 1'b1;
        alu_op_s = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regDst      = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BEQ: begin
        aluSrcA  = 1'b1;
        alu_op_s = ALUOP_SUB;
        pcSrc    = PC_ALUOUT;
        branch_s = 1'b1;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      S_JUMP: begin
        pcSrc      = PC_JUMP;
        pc_write_s = 1'b1;
      end
      default: alu_op_s = ALUOP_ADD;
    endcase
  end

  // zero is 0 when the operands compare equal, i.e. branch taken
  assign pcEn      = (pc_write_s | (branch_s & ~zero)) & ~reset;
  assign memWrite  = mem_write_s & ~reset;
  assign irWrite   = ir_write_s & ~reset;
  assign regWrite  = reg_write_s & ~reset;
  assign illegalOp = illegal_s & ~reset;

  alu_decoder u_alu_decoder (
    .aluOp      (alu_op_s),
    .funct      (funct),
    .aluControl (aluControl)
  );

endmodule
